// File: rtl/dmem_if.sv
// Load/store port between the core and the data-memory responder.
// mem_w is a one-cycle store strobe with no back-pressure: a store is
// taken on every rising clock edge where mem_w is high, and the read
// path is purely combinational from addr/DMType.
interface dmem_if;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  DMType;
    logic [31:0] rdata;
    logic [31:0] io_out;
    logic        fault;
    logic [31:0] fault_addr;
    logic [15:0] store_cnt;

    // Core side: drives the request, observes read data and status.
    modport master (
        output mem_w, addr, wdata, DMType,
        input  rdata, io_out, fault, fault_addr, store_cnt
    );

    // Memory side: consumes the request, returns read data and status.
    modport slave (
        input  mem_w, addr, wdata, DMType,
        output rdata, io_out, fault, fault_addr, store_cnt
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle RISC-V core.
// RAM of DEPTH words plus one MMIO output register. Reads are
// combinational and right-aligned; stores take effect on the rising edge
// with byte-lane enables. Bad stores (misaligned or unmapped) are
// dropped and latch a sticky fault with the first offending address.
module dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_ADDR = 32'hFFFF_0000
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    // Storage
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       io_q,         io_d;
    logic              fault_q,      fault_d;
    logic [31:0]       fault_addr_q, fault_addr_d;
    logic [15:0]       store_cnt_q,  store_cnt_d;

    // Decode
    size_e             size;
    logic              mmio_hit;
    logic              ram_hit;
    logic              aligned;
    logic [ADDR_W-1:0] word_idx;

    // Write control
    logic              store_ok;
    logic              store_bad;
    logic              ram_we;
    logic              io_we;
    logic [3:0]        be;
    logic [31:0]       wlane;

    // Read path
    logic [31:0]       rd_src;
    logic [31:0]       rd_data;

    // Access size from DMType; signedness only matters to the core, and
    // unused encodings behave as word accesses.
    always_comb begin
        size = SZ_WORD;
        case (bus.DMType)
            3'b001, 3'b010: size = SZ_HALF;
            3'b011, 3'b100: size = SZ_BYTE;
            default:        size = SZ_WORD;
        endcase
    end

    // Address decode and natural-alignment check. MMIO wins over RAM so
    // that a small DEPTH can never alias the register.
    always_comb begin
        mmio_hit = (bus.addr[31:2] == MMIO_ADDR[31:2]);
        ram_hit  = !mmio_hit && (bus.addr[31:ADDR_W+2] == '0);
        word_idx = bus.addr[ADDR_W+1:2];
        aligned  = 1'b0;
        case (size)
            SZ_HALF: aligned = !bus.addr[0];
            SZ_BYTE: aligned = 1'b1;
            default: aligned = (bus.addr[1:0] == 2'b00);
        endcase
    end

    // Store classification. Stores seen while reset is asserted are
    // neither committed nor counted as faults.
    always_comb begin
        store_ok  = rst && bus.mem_w && aligned && (ram_hit || mmio_hit);
        store_bad = rst && bus.mem_w && !(aligned && (ram_hit || mmio_hit));
        ram_we    = store_ok && ram_hit;
        io_we     = store_ok && mmio_hit;
    end

    // Byte enables and lane data. The store value is replicated across
    // every lane so the enables alone pick which lanes change.
    always_comb begin
        be    = 4'b1111;
        wlane = bus.wdata;
        case (size)
            SZ_HALF: begin
                be    = 4'b0011 << {bus.addr[1], 1'b0};
                wlane = {2{bus.wdata[15:0]}};
            end
            SZ_BYTE: begin
                be    = 4'b0001 << bus.addr[1:0];
                wlane = {4{bus.wdata[7:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = bus.wdata;
            end
        endcase
    end

    // Next-state for the MMIO register, the commit counter and the
    // sticky fault capture (first bad store only).
    always_comb begin
        io_d = io_q;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                io_d[8*k +: 8] = wlane[8*k +: 8];
            end
        end
        store_cnt_d  = store_cnt_q + 16'd1;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (store_bad && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = bus.addr;
        end
    end

    // RAM byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem_q[word_idx][8*k +: 8] <= wlane[8*k +: 8];
                end
            end
        end
    end

    // Status and MMIO registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_q         <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            store_cnt_q  <= '0;
        end else begin
            if (io_we) begin
                io_q <= io_d;
            end
            if (store_ok) begin
                store_cnt_q <= store_cnt_d;
            end
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Combinational read: pick the source word, then the addressed lane,
    // right-aligned with upper bits zero. Misaligned or unmapped reads
    // return zero and never fault, since addr is live every cycle.
    always_comb begin
        rd_src = '0;
        if (mmio_hit) begin
            rd_src = io_q;
        end else if (ram_hit) begin
            rd_src = mem_q[word_idx];
        end
        rd_data = '0;
        if (aligned) begin
            case (size)
                SZ_HALF: rd_data = {16'h0000, bus.addr[1] ? rd_src[31:16] : rd_src[15:0]};
                SZ_BYTE: begin
                    case (bus.addr[1:0])
                        2'd0:    rd_data = {24'h0, rd_src[7:0]};
                        2'd1:    rd_data = {24'h0, rd_src[15:8]};
                        2'd2:    rd_data = {24'h0, rd_src[23:16]};
                        default: rd_data = {24'h0, rd_src[31:24]};
                    endcase
                end
                default: rd_data = rd_src;
            endcase
        end
    end

    assign bus.rdata      = rd_data;
    assign bus.io_out     = io_q;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;
    assign bus.store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder with a byte-addressed
// reference model and a scoreboard drained by an independent monitor.
module tb_dmem_responder;

    localparam logic [31:0] MMIO     = 32'hFFFF_0000;
    localparam logic [31:0] RAM_SIZE = 32'd4096;

    logic clk;
    logic rst;

    dmem_if bus ();

    dmem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_ram [bit [31:0]];
    logic [7:0]  ref_io  [4];
    logic        ref_fault;
    logic [31:0] ref_fault_addr;
    logic [15:0] ref_cnt;

    typedef struct {
        logic [31:0] addr;
        logic        rd_known;
        logic [31:0] rdata;
        logic [31:0] io;
        logic        f;
        logic [31:0] fa;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic int acc_size(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    // 0 = unmapped, 1 = MMIO, 2 = RAM
    function automatic int region(input logic [31:0] a);
        if (a[31:2] == MMIO[31:2]) return 1;
        if (a < RAM_SIZE) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) ref_io[i] = 8'h00;
        ref_fault      = 1'b0;
        ref_fault_addr = 32'h0;
        ref_cnt        = 16'h0;
    endfunction

    function automatic void model_read(input logic [31:0] a, input logic [2:0] t,
                                       output logic known, output logic [31:0] v);
        int sz;
        int r;
        logic [31:0] ba;
        logic [7:0]  bt;
        sz    = acc_size(t);
        r     = region(a);
        v     = 32'h0;
        known = 1'b1;
        if (r == 0 || (a % sz) != 0) return;
        for (int b = 0; b < sz; b++) begin
            ba = a + b;
            bt = 8'h00;
            if (r == 1) bt = ref_io[ba[1:0]];
            else if (ref_ram.exists(ba)) bt = ref_ram[ba];
            else known = 1'b0;
            v = v | ({24'h0, bt} << (8 * b));
        end
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                        input logic [2:0] t);
        int sz;
        int r;
        logic [31:0] ba;
        sz = acc_size(t);
        r  = region(a);
        if (r != 0 && (a % sz) == 0) begin
            for (int b = 0; b < sz; b++) begin
                ba = a + b;
                if (r == 1) ref_io[ba[1:0]] = d[8*b +: 8];
                else        ref_ram[ba]     = d[8*b +: 8];
            end
            ref_cnt = ref_cnt + 16'd1;
        end else if (!ref_fault) begin
            ref_fault      = 1'b1;
            ref_fault_addr = a;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pushed expectation is compared at the next falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.rd_known) check32($sformatf("rdata@%h", e.addr), bus.rdata, e.rdata);
            check32("io_out", bus.io_out, e.io);
            check32("fault", {31'h0, bus.fault}, {31'h0, e.f});
            check32("fault_addr", bus.fault_addr, e.fa);
            check32("store_cnt", {16'h0, bus.store_cnt}, {16'h0, e.cnt});
        end
    end

    // ---------------- driver ----------------
    // One core cycle: present inputs, record what the outputs must show
    // before the edge (old data for read-during-write), then advance model.
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, input logic use_const, input logic [31:0] cval);
        exp_t e;
        @(posedge clk);
        #1;
        bus.mem_w  = w;
        bus.addr   = a;
        bus.wdata  = d;
        bus.DMType = t;
        e.addr = a;
        model_read(a, t, e.rd_known, e.rdata);
        if (use_const) begin
            e.rd_known = 1'b1;
            e.rdata    = cval;
        end
        e.io  = {ref_io[3], ref_io[2], ref_io[1], ref_io[0]};
        e.f   = ref_fault;
        e.fa  = ref_fault_addr;
        e.cnt = ref_cnt;
        exp_q.push_back(e);
        if (w) model_store(a, d, t);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        drive(1'b1, a, d, t, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] t, input logic [31:0] expv);
        drive(1'b0, a, 32'h0, t, 1'b1, expv);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.mem_w = 1'b0;
        rst       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          sel;
        rst        = 1'b0;
        bus.mem_w  = 1'b0;
        bus.addr   = 32'h0;
        bus.wdata  = 32'h0;
        bus.DMType = 3'd0;
        model_reset();
        do_reset();

        // word store and readback
        st(32'h10, 32'hDEADBEEF, 3'd0);
        rd(32'h10, 3'd0, 32'hDEADBEEF);
        // byte and half lane merges
        st(32'h12, 32'h0000_0055, 3'd3);
        rd(32'h10, 3'd0, 32'hDE55BEEF);
        st(32'h10, 32'h0000_1234, 3'd1);
        rd(32'h10, 3'd0, 32'hDE551234);
        rd(32'h13, 3'd3, 32'h0000_00DE);
        rd(32'h12, 3'd2, 32'h0000_DE55);
        // faults: first one sticks
        st(32'h11, 32'hCAFEF00D, 3'd0);
        rd(32'h10, 3'd0, 32'hDE551234);
        st(32'h8000_0000, 32'h1, 3'd0);
        rd(32'h11, 3'd0, 32'h0);
        rd(32'h8000_0000, 3'd0, 32'h0);
        // MMIO register
        st(MMIO, 32'hA5A5_0001, 3'd0);
        rd(MMIO, 3'd0, 32'hA5A5_0001);
        st(MMIO + 32'd3, 32'h0000_007F, 3'd3);
        rd(MMIO + 32'd2, 3'd1, 32'h0000_7FA5);
        // RAM edges and read-during-write returning old data
        st(32'hFFC, 32'h1357_9BDF, 3'd0);
        rd(32'hFFC, 3'd0, 32'h1357_9BDF);
        rd(32'h1000, 3'd0, 32'h0);
        drive(1'b1, 32'h10, 32'h1111_2222, 3'd0, 1'b1, 32'hDE551234);
        rd(32'h10, 3'd0, 32'h1111_2222);

        // randomized traffic from a fresh reset so the first fault is random
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 13)      a = 32'($urandom_range(0, 63));
            else if (sel < 16) a = MMIO + 32'($urandom_range(0, 3));
            else if (sel < 18) a = RAM_SIZE + 32'($urandom_range(0, 255));
            else               a = $urandom;
            drive(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), 1'b0, 32'h0);
        end

        // asynchronous reset with a store pending and no clock edge
        st(32'h40, 32'h0BAD_CAFE, 3'd0);
        st(32'h41, 32'h0, 3'd0);
        @(posedge clk);
        #1;
        bus.mem_w  = 1'b1;
        bus.addr   = 32'h40;
        bus.wdata  = 32'hFFFF_FFFF;
        bus.DMType = 3'd0;
        #2;
        rst = 1'b0;
        #1;
        check32("async io_out", bus.io_out, 32'h0);
        check32("async fault", {31'h0, bus.fault}, 32'h0);
        check32("async fault_addr", bus.fault_addr, 32'h0);
        check32("async store_cnt", {16'h0, bus.store_cnt}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        bus.mem_w = 1'b0;
        rst       = 1'b1;
        rd(32'h40, 3'd0, 32'h0BAD_CAFE);

        // store counter wrap
        for (int i = 0; i < 65535; i++) begin
            st(32'h20 + 32'((i % 8) * 4), $urandom, 3'd0);
        end
        drive(1'b0, 32'h20, 32'h0, 3'd0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check32("cnt_ffff", {16'h0, bus.store_cnt}, 32'h0000_FFFF);
        st(32'h20, 32'h0, 3'd0);
        drive(1'b0, 32'h20, 32'h0, 3'd0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check32("cnt_wrap", {16'h0, bus.store_cnt}, 32'h0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
